// File: rtl/ddr_native_responder.sv
// Behavioural DDR native-interface responder: init handshake, serialized
// write/read bursts against an internal word memory, sticky illegal-command flag.
module ddr_native_responder #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 26,
  parameter int unsigned MEM_AW          = 10,
  parameter int unsigned INIT_CYCLES     = 16,
  parameter int unsigned RD_LATENCY      = 4,
  parameter int unsigned BEATS_PER_BURST = 2
) (
  input  logic                    sclk,
  input  logic                    rstn,
  input  logic                    init_start,
  output logic                    init_done,
  input  logic [3:0]              cmd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [4:0]              cmd_burst_cnt,
  input  logic                    ofly_burst_len,
  input  logic                    cmd_valid,
  output logic                    cmd_rdy,
  output logic                    datain_rdy,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] data_mask,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_data_valid,
  output logic                    err_cmd
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned BW     = $clog2(BEATS_PER_BURST * 32 + 1);
  localparam int unsigned IW     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned LW     = $clog2(RD_LATENCY);

  localparam logic [3:0] CMD_READ  = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACK, S_WR, S_RD, S_RDWAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [MEM_AW-1:0]       addr_q, addr_d;
  logic [BW-1:0]           beats_q, beats_d;
  logic [BW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           xfer_q, xfer_d;
  logic [LW-1:0]           wait_q, wait_d;
  logic                    cmd_rdy_q, cmd_rdy_d;
  logic                    datain_rdy_q, datain_rdy_d;
  logic                    wr_pend_q, wr_pend_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   wr_word_c;
  logic [MEM_AW-1:0]       wr_idx_c, rd_idx_c;
  logic [5:0]              units_c;
  logic [BW-1:0]           req_beats_c;
  logic                    we_c;
  logic                    rd_issue_c;
  logic                    unused_ok;

  assign unused_ok = ^{ofly_burst_len, addr[ADDR_WIDTH-1:MEM_AW]};

  // A burst count of zero encodes the maximum of 32 units.
  assign units_c     = (cmd_burst_cnt == 5'd0) ? 6'd32 : {1'b0, cmd_burst_cnt};
  assign req_beats_c = BW'(BEATS_PER_BURST) * BW'(units_c);
  assign wr_idx_c    = addr_q + MEM_AW'(xfer_q);
  assign rd_idx_c    = addr_q + MEM_AW'(cnt_q);

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    assign wr_word_c[8*b +: 8] = data_mask[b] ? write_data[8*b +: 8]
                                              : mem_q[wr_idx_c][8*b +: 8];
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_done_d  = init_done_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    beats_d      = beats_q;
    cnt_d        = cnt_q;
    xfer_d       = xfer_q;
    wait_d       = wait_q;
    cmd_rdy_d    = 1'b0;
    datain_rdy_d = 1'b0;
    wr_pend_d    = datain_rdy_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    err_d        = err_q;
    we_c         = 1'b0;
    rd_issue_c   = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_start) begin
          if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_cnt_d = init_cnt_q + IW'(1);
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_ACK;
          cmd_rdy_d = 1'b1;
          cmd_d     = cmd;
          addr_d    = addr[MEM_AW-1:0];
          beats_d   = req_beats_c;
          cnt_d     = '0;
          xfer_d    = '0;
          wait_d    = '0;
        end
      end
      S_ACK: begin
        if (cmd_q == CMD_WRITE) begin
          state_d      = S_WR;
          datain_rdy_d = 1'b1;
          cnt_d        = BW'(1);
        end else if (cmd_q == CMD_READ) begin
          state_d = S_RDWAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        // Data for a datain_rdy cycle arrives one cycle later (wr_pend_q).
        if (cnt_q < beats_q) begin
          datain_rdy_d = 1'b1;
          cnt_d        = cnt_q + BW'(1);
        end
        if (wr_pend_q) begin
          we_c   = 1'b1;
          xfer_d = xfer_q + BW'(1);
          if (xfer_q == beats_q - BW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RDWAIT: begin
        // The last wait cycle already issues beat 0 so latency 2 works.
        if (wait_q == LW'(RD_LATENCY - 2)) begin
          rd_issue_c = 1'b1;
          state_d    = S_RD;
        end else begin
          wait_d = wait_q + LW'(1);
        end
      end
      S_RD: begin
        rd_issue_c = 1'b1;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    if (rd_issue_c) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[rd_idx_c];
      cnt_d      = cnt_q + BW'(1);
      if (cnt_q == beats_q - BW'(1)) begin
        state_d = S_IDLE;
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      beats_q      <= '0;
      cnt_q        <= '0;
      xfer_q       <= '0;
      wait_q       <= '0;
      cmd_rdy_q    <= 1'b0;
      datain_rdy_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      beats_q      <= beats_d;
      cnt_q        <= cnt_d;
      xfer_q       <= xfer_d;
      wait_q       <= wait_d;
      cmd_rdy_q    <= cmd_rdy_d;
      datain_rdy_q <= datain_rdy_d;
      wr_pend_q    <= wr_pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
    end
  end

  // Memory contents survive reset; a write in a reset cycle is dropped.
  always_ff @(posedge sclk) begin
    if (rstn && we_c) begin
      mem_q[wr_idx_c] <= wr_word_c;
    end
  end

  assign init_done       = init_done_q;
  assign cmd_rdy         = cmd_rdy_q;
  assign datain_rdy      = datain_rdy_q;
  assign read_data       = rd_data_q;
  assign read_data_valid = rd_valid_q;
  assign err_cmd         = err_q;

endmodule

// File: tb/tb_ddr_native_responder.sv
// Randomized bench for ddr_native_responder against a word-array reference
// model with expected handshake timing derived from the burst rules.
module tb_ddr_native_responder;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 26;
  localparam int unsigned MAW   = 10;
  localparam int unsigned DEPTH = 1 << MAW;
  localparam int unsigned RDL   = 4;
  localparam int unsigned BPB   = 2;

  logic          sclk = 1'b0;
  logic          rstn;
  logic          init_start;
  logic          init_done;
  logic [3:0]    cmd;
  logic [AW-1:0] addr;
  logic [4:0]    cmd_burst_cnt;
  logic          ofly_burst_len;
  logic          cmd_valid;
  logic          cmd_rdy;
  logic          datain_rdy;
  logic [DW-1:0] write_data;
  logic [7:0]    data_mask;
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic          err_cmd;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_ok  [DEPTH];
  logic [DW-1:0] wd [64];
  logic [7:0]    wm [64];
  logic [DW-1:0] last_rd;
  bit            last_ok;

  logic [AW-1:0] ra;
  logic [4:0]    rbc;
  logic [AW-1:0] rst_addr;

  ddr_native_responder dut (
    .sclk            (sclk),
    .rstn            (rstn),
    .init_start      (init_start),
    .init_done       (init_done),
    .cmd             (cmd),
    .addr            (addr),
    .cmd_burst_cnt   (cmd_burst_cnt),
    .ofly_burst_len  (ofly_burst_len),
    .cmd_valid       (cmd_valid),
    .cmd_rdy         (cmd_rdy),
    .datain_rdy      (datain_rdy),
    .write_data      (write_data),
    .data_mask       (data_mask),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .err_cmd         (err_cmd)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int beats(input logic [4:0] bc);
    return BPB * ((bc == 5'd0) ? 32 : int'(bc));
  endfunction

  task automatic reset_check();
    @(negedge sclk);
    check("rst_init_done", init_done, 1'b0);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_datain_rdy", datain_rdy, 1'b0);
    check("rst_rvalid", read_data_valid, 1'b0);
    check("rst_rdata", read_data, 64'h0);
    check("rst_err", err_cmd, 1'b0);
    last_rd = '0;
    last_ok = 1'b1;
  endtask

  // Release reset and count init_start-high edges until init_done.
  task automatic do_init(input int pause_at, input int pause_len, input bit stall);
    int hi = 0;
    int cyc = 0;
    bit done = 0;
    bit seen_rdy = 0;
    rstn      = 1'b1;
    cmd       = 4'b0001;
    cmd_valid = stall;
    while (!done && cyc < 200) begin
      init_start = !(cyc >= pause_at && cyc < pause_at + pause_len);
      @(posedge sclk);
      if (init_start) hi++;
      @(negedge sclk);
      cyc++;
      if (cmd_rdy) seen_rdy = 1;
      if (init_done) done = 1;
    end
    cmd_valid  = 1'b0;
    init_start = 1'b1;
    check("init_done", done, 1'b1);
    check("init_edges", hi, 16);
    check("init_stall_rdy", seen_rdy, 1'b0);
  endtask

  task automatic issue(input logic [3:0] c, input logic [AW-1:0] a, input logic [4:0] bc);
    int w = 0;
    bit got = 0;
    cmd            = c;
    addr           = a;
    cmd_burst_cnt  = bc;
    ofly_burst_len = 1'($urandom);
    cmd_valid      = 1'b1;
    while (!got && w < 20) begin
      @(negedge sclk);
      w++;
      if (cmd_rdy) got = 1;
    end
    cmd_valid = 1'b0;
    cmd       = 4'($urandom);
    addr      = AW'($urandom);
    check("ack_latency", w, 1);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [4:0] bc, input int rst_at);
    int n = beats(bc);
    int j = 0;
    bit prev = 0;
    bit dr;
    logic [MAW-1:0] idx;
    issue(4'b0010, a, bc);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge sclk);
      dr = datain_rdy;
      check("datain_rdy", dr, (k <= n));
      check("cmd_rdy_wr", cmd_rdy, 1'b0);
      check("rvalid_wr", read_data_valid, 1'b0);
      idx = a[MAW-1:0] + MAW'(j);
      if (k == rst_at) begin
        rstn = 1'b0;
        ref_ok[idx] = 1'b0;
        return;
      end
      if (prev) begin
        write_data = wd[j];
        data_mask  = wm[j];
        for (int b = 0; b < 8; b++)
          if (wm[j][b]) ref_mem[idx][8*b +: 8] = wd[j][8*b +: 8];
        if (wm[j] == 8'hFF) ref_ok[idx] = 1'b1;
        j++;
      end
      prev = dr;
    end
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [4:0] bc, input bit poke);
    int n = beats(bc);
    bit exp_v;
    logic [MAW-1:0] idx;
    issue(4'b0001, a, bc);
    for (int k = 1; k <= int'(RDL) + n; k++) begin
      @(negedge sclk);
      if (poke) begin
        cmd       = 4'b0111;
        cmd_valid = (k <= 2);
      end
      check("cmd_rdy_rd", cmd_rdy, 1'b0);
      check("datain_rdy_rd", datain_rdy, 1'b0);
      exp_v = (k >= int'(RDL) && k < int'(RDL) + n);
      check("rvalid", read_data_valid, exp_v);
      if (exp_v && read_data_valid) begin
        idx = a[MAW-1:0] + MAW'(k - int'(RDL));
        if (ref_ok[idx]) begin
          check("rdata", read_data, ref_mem[idx]);
          last_rd = ref_mem[idx];
          last_ok = 1'b1;
        end else begin
          last_ok = 1'b0;
        end
      end else if (!read_data_valid && last_ok) begin
        check("rdata_hold", read_data, last_rd);
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; init_start = 1'b0; cmd_valid = 1'b0; cmd = '0; addr = '0;
    cmd_burst_cnt = '0; ofly_burst_len = 1'b0; write_data = '0; data_mask = '0;
    last_rd = '0; last_ok = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b0;
    end
    repeat (2) @(negedge sclk);
    reset_check();
    do_init(0, 0, 1'b1);

    // Fill the whole memory with 64-beat bursts.
    for (int blk = 0; blk < int'(DEPTH) / 64; blk++) begin
      for (int j = 0; j < 64; j++) begin
        wd[j] = {$urandom, $urandom};
        wm[j] = 8'hFF;
      end
      wr_burst({16'($urandom), MAW'(blk * 64)}, 5'd0, -1);
    end

    wd[0] = 64'hA5A5_0001_DEAD_BEEF; wm[0] = 8'hFF;
    wd[1] = 64'h5A5A_0002_CAFE_F00D; wm[1] = 8'hFF;
    wr_burst(AW'(16'h0010), 5'd1, -1);
    rd_burst(AW'(16'h0010), 5'd1, 1'b0);

    wd[0] = 64'h1111_2222_3333_4444; wd[1] = 64'h5555_6666_7777_8888;
    wr_burst(AW'(DEPTH - 1), 5'd1, -1);
    rd_burst(AW'(DEPTH - 1), 5'd1, 1'b0);

    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; wm[0] = 8'hFF; wm[1] = 8'h00;
    wr_burst(AW'(16'h0040), 5'd1, -1);
    wd[0] = 64'h0; wm[0] = 8'h0F;
    wr_burst(AW'(16'h0040), 5'd1, -1);
    rd_burst(AW'(16'h0040), 5'd1, 1'b0);

    rd_burst(AW'($urandom), 5'd2, 1'b1);
    check("no_err_after_drop", err_cmd, 1'b0);

    issue(4'b0111, AW'($urandom), 5'($urandom));
    for (int k = 1; k <= 4; k++) begin
      @(negedge sclk);
      check("err_datain_rdy", datain_rdy, 1'b0);
      check("err_rvalid", read_data_valid, 1'b0);
      check("err_cmd_rdy", cmd_rdy, 1'b0);
      check("err_cmd", err_cmd, 1'b1);
    end

    rd_burst(AW'($urandom), 5'd0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra  = AW'($urandom);
      rbc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 64; j++) begin
          wd[j] = {$urandom, $urandom};
          wm[j] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        end
        wr_burst(ra, rbc, -1);
      end else begin
        rd_burst(ra, rbc, 1'b0);
      end
    end
    check("err_sticky", err_cmd, 1'b1);

    // Reset during the second write beat; beat 0 must survive.
    rst_addr = AW'($urandom);
    wd[0] = {$urandom, $urandom}; wm[0] = 8'hFF;
    wd[1] = {$urandom, $urandom}; wm[1] = 8'hFF;
    wr_burst(rst_addr, 5'd1, 3);
    reset_check();
    do_init(4, 5, 1'b0);
    rd_burst(rst_addr, 5'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
